// File: rtl/trng_seq_pkg.sv
// Shared types and constants for the TRNG/BIST run sequencer.
package trng_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_ARM  = 3'd2,
    ST_RUN  = 3'd3,
    ST_RESP = 3'd4
  } seq_state_t;

  localparam int ERR_TIMEOUT  = 0;
  localparam int ERR_HEALTH   = 1;
  localparam int CORE_RUN_LEN = 32768;

endpackage

// File: rtl/trng_rct_check.sv
// Repetition-count health test on the sampled serial stream.
// Only compiled in when TRNG_SEQ_HEALTH_EN is defined.
`ifdef TRNG_SEQ_HEALTH_EN
module trng_rct_check #(
  parameter int RCT_LIMIT = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic sample,
  input  logic bit_in,
  output logic fail
);

  logic       prev_q;
  logic       have_prev_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (bit_in != prev_q)  cnt_d = 8'd1;
    else if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q      <= 1'b0;
      have_prev_q <= 1'b0;
      cnt_q       <= 8'd0;
      fail        <= 1'b0;
    end else if (clear) begin
      prev_q      <= 1'b0;
      have_prev_q <= 1'b0;
      cnt_q       <= 8'd0;
      fail        <= 1'b0;
    end else if (sample) begin
      prev_q      <= bit_in;
      have_prev_q <= 1'b1;
      // The first sample of a run only seeds the previous-bit register.
      if (have_prev_q) begin
        cnt_q <= cnt_d;
        if (cnt_d >= 8'(RCT_LIMIT)) fail <= 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/trng_seq_ctrl.sv
// Request-driven sequencer for the TRNG/BIST core: clear, arm, run, collect, respond.
// Optional repetition-count health test enabled by defining TRNG_SEQ_HEALTH_EN.
module trng_seq_ctrl
  import trng_seq_pkg::*;
#(
  parameter int WORD_W    = 64,
  parameter int TIMEOUT   = 40000,
  parameter int RCT_LIMIT = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_bist,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_data,
  output logic [1:0]        rsp_err,
  output logic              core_reset,
  output logic              core_run,
  output logic              core_bist,
  input  logic              core_enable,
  input  logic              core_gating,
  input  logic              core_serial,
  input  logic              core_ready
);

  localparam int            TW     = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  seq_state_t    state_q, state_d;
  logic          bist_q;
  logic          clr_cnt_q;
  logic          rdy_q;
  logic          tout_q;
  logic          health_fail;
  logic [TW-1:0] tcnt_q;
  logic          accept, sample, tout_hit;

  assign accept   = (state_q == ST_IDLE) && req_valid;
  assign sample   = (state_q == ST_RUN) && core_enable && core_gating;
  assign tout_hit = (tcnt_q == T_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_valid) state_d = ST_CLR;
      ST_CLR:  if (clr_cnt_q) state_d = ST_ARM;
      ST_ARM:  state_d = ST_RUN;
      ST_RUN:  if (rdy_q || tout_hit) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bist_q     <= 1'b0;
      clr_cnt_q  <= 1'b0;
      rdy_q      <= 1'b0;
      tcnt_q     <= '0;
      tout_q     <= 1'b0;
      rsp_data   <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      core_reset <= 1'b1;
      core_run   <= 1'b0;
      core_bist  <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere here; every flop sees pre-edge values.
      state_q    <= state_d;
      rdy_q      <= core_ready;
      req_ready  <= (state_d == ST_IDLE);
      rsp_valid  <= (state_d == ST_RESP);
      core_reset <= (state_d == ST_CLR);
      core_run   <= (state_d == ST_RUN);

      if (accept) begin
        bist_q    <= req_bist;
        clr_cnt_q <= 1'b0;
        tcnt_q    <= '0;
        tout_q    <= 1'b0;
        rsp_data  <= '0;
      end

      if (state_q == ST_CLR) clr_cnt_q <= 1'b1;

      if (state_d == ST_ARM)      core_bist <= bist_q;
      else if (state_d == ST_CLR) core_bist <= 1'b0;

      // Completion takes priority over a simultaneous timeout.
      if (state_q == ST_RUN) begin
        if (!tout_hit)           tcnt_q <= tcnt_q + 1'b1;
        if (!rdy_q && tout_hit)  tout_q <= 1'b1;
      end

      if (sample) rsp_data <= {rsp_data[WORD_W-2:0], core_serial};
    end
  end

`ifdef TRNG_SEQ_HEALTH_EN
  trng_rct_check #(
    .RCT_LIMIT(RCT_LIMIT)
  ) u_rct (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .sample (sample),
    .bit_in (core_serial),
    .fail   (health_fail)
  );
`else
  assign health_fail = 1'b0;
`endif

  assign rsp_err[ERR_TIMEOUT] = tout_q;
  assign rsp_err[ERR_HEALTH]  = health_fail;

endmodule
